// File: rtl/bit_serial_adder_if.sv
// Host-side bundle for the bit-serial adder sequencer.
// Host drives request/operands; sequencer returns status and result.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one shared full-adder cell, LSB first, one bit per clock.
// Operands latch on accept; result and done register on the last bit.
module fulladder (
  input  logic i0,
  input  logic i1,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = i0 ^ i1 ^ ci;
  assign co = (i0 & i1) | (ci & (i0 ^ i1));
endmodule

module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  bit_serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             fa_s, fa_co;
  logic [WIDTH:0]   s_shift;

  fulladder u_fa (
    .i0 (a_sr_q[0]),
    .i1 (b_sr_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    // New sum bit enters at the MSB; also safe when WIDTH is 1.
    s_shift = {fa_s, s_sr_q} >> 1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_shift[WIDTH-1:0];
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = s_shift[WIDTH-1:0];
          cout_d  = fa_co;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Scoreboard bench: WIDTH=8 and WIDTH=1 sequencers against a+b+cin.
// Monitors check busy/done timing, results and result hold every cycle.
module tb_bit_serial_adder_ctrl;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  int         t0_8;
  int         t0_1;
  logic [8:0] held8;
  logic [1:0] held1;
  logic [8:0] q8[$];
  logic [1:0] q1[$];

  bit_serial_adder_if #(.WIDTH(8)) h8 ();
  bit_serial_adder_if #(.WIDTH(1)) h1 ();

  bit_serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (h8.slave)
  );

  bit_serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (h1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h",
               name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy8", h8.busy, (cyc >= t0_8) && (cyc <= t0_8 + 8));
      chk("done8", h8.done, cyc == t0_8 + 8);
      if (h8.done) begin
        chk("q8_has_entry", q8.size() != 0, 1);
        if (q8.size() != 0) begin
          held8 = q8.pop_front();
          chk("result8", {h8.cout, h8.sum}, held8);
        end
      end else begin
        chk("hold8", {h8.cout, h8.sum}, held8);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy1", h1.busy, (cyc >= t0_1) && (cyc <= t0_1 + 1));
      chk("done1", h1.done, cyc == t0_1 + 1);
      if (h1.done) begin
        chk("q1_has_entry", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          held1 = q1.pop_front();
          chk("result1", {h1.cout, h1.sum}, held1);
        end
      end else begin
        chk("hold1", {h1.cout, h1.sum}, held1);
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic ci, input bit hold);
    @(negedge clk);
    h8.start = 1'b1;
    h8.a     = a;
    h8.b     = b;
    h8.cin   = ci;
    q8.push_back(9'(a) + 9'(b) + 9'(ci));
    @(posedge clk);
    #1;
    t0_8     = cyc;
    h8.start = hold;
    h8.a     = 8'($urandom);
    h8.b     = 8'($urandom);
    h8.cin   = 1'($urandom);
    repeat (9) @(posedge clk);
  endtask

  task automatic op1(input logic a, input logic b,
                     input logic ci, input bit hold);
    @(negedge clk);
    h1.start = 1'b1;
    h1.a     = a;
    h1.b     = b;
    h1.cin   = ci;
    q1.push_back(2'(a) + 2'(b) + 2'(ci));
    @(posedge clk);
    #1;
    t0_1     = cyc;
    h1.start = hold;
    h1.a     = 1'($urandom);
    h1.b     = 1'($urandom);
    h1.cin   = 1'($urandom);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    t0_8     = -1000;
    t0_1     = -1000;
    held8    = '0;
    held1    = '0;
    h8.start = 1'b0;
    h8.a     = '0;
    h8.b     = '0;
    h8.cin   = 1'b0;
    h1.start = 1'b0;
    h1.a     = '0;
    h1.b     = '0;
    h1.cin   = 1'b0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", h8.busy, 0);
    chk("rst_done8", h8.done, 0);
    chk("rst_res8", {h8.cout, h8.sum}, 0);
    chk("rst_busy1", h1.busy, 0);
    chk("rst_res1", {h1.cout, h1.sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0], 1'b1);
    end
    h1.start = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b1);
    op8(8'hFF, 8'h00, 1'b1, 1'b1);
    op8(8'h00, 8'h00, 1'b0, 1'b1);
    op8(8'hFF, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end
    h8.start = 1'b0;

    @(negedge clk);
    h8.start = 1'b1;
    h8.a     = 8'hC3;
    h8.b     = 8'h7E;
    h8.cin   = 1'b1;
    q8.push_back(9'h142);
    @(posedge clk);
    #1;
    t0_8     = cyc;
    h8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy8", h8.busy, 0);
    chk("arst_done8", h8.done, 0);
    chk("arst_sum8", h8.sum, 0);
    chk("arst_cout8", h8.cout, 0);
    q8.delete();
    held8 = '0;
    held1 = '0;
    t0_8  = -1000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);

    op8(8'h81, 8'h7F, 1'b0, 1'b0);
    op8(8'h12, 8'h34, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
